// File: rtl/dac_wl_responder.sv
// DAC-side responder for the dac_valid/dac_ready wordline handshake: settle, one-cycle ack,
// fixed-width wordline pulse from the captured bitmap, then a recovery gap before the next accept.
module dac_wl_responder #(
    parameter int NUM_INPUTS     = 64,
    parameter int READY_DELAY    = 2,
    parameter int PULSE_CYCLES   = 4,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_INPUTS-1:0]           i_wl_spike,
    input  logic                            i_dac_valid,
    output logic                            o_dac_ready,
    output logic [NUM_INPUTS-1:0]           o_wl_drive,
    output logic                            o_drive_active,
    output logic [$clog2(NUM_INPUTS+1)-1:0] o_spike_count,
    output logic [15:0]                     o_pulse_total,
    output logic                            o_protocol_err
);
    localparam int SC_W  = $clog2(NUM_INPUTS + 1);
    localparam int MAX_A = (READY_DELAY > PULSE_CYCLES) ? READY_DELAY : PULSE_CYCLES;
    localparam int MAX_V = (MAX_A > RECOVER_CYCLES) ? MAX_A : RECOVER_CYCLES;
    localparam int CNT_W = (MAX_V < 2) ? 1 : $clog2(MAX_V + 1);

    localparam logic [CNT_W-1:0] CNT_SETTLE  = CNT_W'(READY_DELAY);
    localparam logic [CNT_W-1:0] CNT_PULSE   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_RECOVER = CNT_W'((RECOVER_CYCLES == 0) ? 0 : RECOVER_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACK, S_DRIVE, S_RECOVER} state_t;

    state_t                  r_state, w_state_nx;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
    logic                    r_ready, w_ready_nx;
    logic [NUM_INPUTS-1:0]   r_wl_drive, w_wl_drive_nx;
    logic                    r_active, w_active_nx;
    logic [SC_W-1:0]         r_spike_count, w_spike_count_nx;
    logic [15:0]             r_pulse_total, w_pulse_total_nx;
    logic                    r_perr, w_perr_nx;
    logic [SC_W-1:0]         w_pop;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_INPUTS; i++) w_pop = w_pop + SC_W'(i_wl_spike[i]);
    end

    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_ready_nx       = 1'b0;
        w_wl_drive_nx    = r_wl_drive;
        w_active_nx      = r_active;
        w_spike_count_nx = r_spike_count;
        w_pulse_total_nx = r_pulse_total;
        w_perr_nx        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_dac_valid) begin
                    if (READY_DELAY == 0) begin
                        w_ready_nx = 1'b1;
                        w_state_nx = S_ACK;
                    end else begin
                        w_cnt_nx   = CNT_SETTLE;
                        w_state_nx = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (!i_dac_valid) begin
                    w_perr_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_ready_nx = 1'b1;
                    w_state_nx = S_ACK;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_ACK: begin
                // dac_ready is only ever held for this single cycle, so the request can't be re-acked.
                if (i_dac_valid) begin
                    w_wl_drive_nx    = i_wl_spike;
                    w_spike_count_nx = w_pop;
                    w_active_nx      = 1'b1;
                    w_cnt_nx         = CNT_PULSE;
                    w_state_nx       = S_DRIVE;
                end else begin
                    w_perr_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_wl_drive_nx    = '0;
                    w_active_nx      = 1'b0;
                    w_pulse_total_nx = r_pulse_total + 16'd1;
                    w_cnt_nx         = CNT_RECOVER;
                    w_state_nx       = (RECOVER_CYCLES == 0) ? S_IDLE : S_RECOVER;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            S_RECOVER: begin
                if (r_cnt == '0) w_state_nx = S_IDLE;
                else             w_cnt_nx   = r_cnt - 1'b1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_ready       <= 1'b0;
            r_wl_drive    <= '0;
            r_active      <= 1'b0;
            r_spike_count <= '0;
            r_pulse_total <= '0;
            r_perr        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_ready       <= w_ready_nx;
            r_wl_drive    <= w_wl_drive_nx;
            r_active      <= w_active_nx;
            r_spike_count <= w_spike_count_nx;
            r_pulse_total <= w_pulse_total_nx;
            r_perr        <= w_perr_nx;
        end
    end

    assign o_dac_ready    = r_ready;
    assign o_wl_drive     = r_wl_drive;
    assign o_drive_active = r_active;
    assign o_spike_count  = r_spike_count;
    assign o_pulse_total  = r_pulse_total;
    assign o_protocol_err = r_perr;
endmodule

// File: tb/tb_dac_wl_responder.sv
// Bench for dac_wl_responder: default-parameter instance plus a fast (0/1/0) instance,
// checked cycle by cycle against a timeline derived from the handshake timing rules.
module tb_dac_wl_responder;
    localparam int N    = 64;
    localparam int SCW  = $clog2(N + 1);
    localparam int RD   = 2;
    localparam int PC   = 4;
    localparam int RC   = 1;
    localparam int RDB  = 0;
    localparam int PCB  = 1;
    localparam int RCB  = 0;
    // Observation index (cycles after request-detect edge) at which dac_ready is visible.
    localparam int ACK_K  = (RD == 0) ? 0 : RD + 1;
    localparam int ACK_B  = (RDB == 0) ? 0 : RDB + 1;
    localparam int LAST_K = ACK_K + PC + 1 + RC;
    localparam int PER_B  = ACK_B + PCB + 2 + RCB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           a_valid, a_ready, a_active, a_perr;
    logic [N-1:0]   a_spike, a_drive;
    logic [SCW-1:0] a_cnt;
    logic [15:0]    a_total;
    logic           b_valid, b_ready, b_active, b_perr;
    logic [N-1:0]   b_spike, b_drive;
    logic [SCW-1:0] b_cnt;
    logic [15:0]    b_total;

    int          checks = 0;
    int          fails  = 0;
    logic [15:0] exp_total;

    dac_wl_responder #(.NUM_INPUTS(N), .READY_DELAY(RD), .PULSE_CYCLES(PC), .RECOVER_CYCLES(RC)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_wl_spike(a_spike), .i_dac_valid(a_valid),
        .o_dac_ready(a_ready), .o_wl_drive(a_drive), .o_drive_active(a_active),
        .o_spike_count(a_cnt), .o_pulse_total(a_total), .o_protocol_err(a_perr));

    dac_wl_responder #(.NUM_INPUTS(N), .READY_DELAY(RDB), .PULSE_CYCLES(PCB), .RECOVER_CYCLES(RCB)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_wl_spike(b_spike), .i_dac_valid(b_valid),
        .o_dac_ready(b_ready), .o_wl_drive(b_drive), .o_drive_active(b_active),
        .o_spike_count(b_cnt), .o_pulse_total(b_total), .o_protocol_err(b_perr));

    function automatic logic [N-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One request on instance A, called at a negedge with A idle. chg_k>=0 swaps the bitmap
    // to bm_late after that observation; keep re-raises dac_valid during DRIVE (pending request).
    task automatic req_a(input logic [N-1:0] bm, input logic [N-1:0] bm_late, input int chg_k, input bit keep);
        logic [N-1:0] cur, hs, exp_drv;
        logic         exp_rdy;
        cur = bm; hs = '0;
        a_spike = cur; a_valid = 1'b1;
        for (int k = 0; k <= LAST_K; k++) begin
            @(posedge clk); @(negedge clk);
            exp_rdy = (k == ACK_K);
            exp_drv = (k > ACK_K && k <= ACK_K + PC) ? hs : '0;
            checks++;
            if (a_ready !== exp_rdy) begin fails++; $display("FAIL a_ready k=%0d got=%b exp=%b", k, a_ready, exp_rdy); end
            checks++;
            if (a_drive !== exp_drv) begin fails++; $display("FAIL a_drive k=%0d got=%h exp=%h", k, a_drive, exp_drv); end
            checks++;
            if (a_active !== (k > ACK_K && k <= ACK_K + PC)) begin
                fails++; $display("FAIL a_active k=%0d got=%b", k, a_active);
            end
            checks++;
            if (a_perr !== 1'b0) begin fails++; $display("FAIL a_perr k=%0d got=%b exp=0", k, a_perr); end
            if (k == ACK_K + 1) begin
                checks++;
                if (int'(a_cnt) !== $countones(hs)) begin
                    fails++; $display("FAIL a_spike_count got=%0d exp=%0d", a_cnt, $countones(hs));
                end
            end
            if (k == ACK_K + PC + 1) begin
                exp_total = exp_total + 16'd1;
                checks++;
                if (a_total !== exp_total) begin fails++; $display("FAIL a_pulse_total got=%h exp=%h", a_total, exp_total); end
            end
            if (k == chg_k) cur = bm_late;
            a_spike = cur;
            if (k == ACK_K) hs = cur;
            if (k == ACK_K + 1) begin a_valid = 1'b0; a_spike = rnd64(); end
            if (keep && k == ACK_K + 2) begin a_valid = 1'b1; a_spike = rnd64(); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; a_spike = '0; b_valid = 1'b0; b_spike = '0;
        exp_total = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_ready, a_drive, a_active, a_cnt, a_total, a_perr} !== '0) begin
            fails++; $display("FAIL reset_a got ready=%b drive=%h act=%b cnt=%0d tot=%h err=%b",
                              a_ready, a_drive, a_active, a_cnt, a_total, a_perr);
        end
        checks++;
        if ({b_ready, b_drive, b_active, b_cnt, b_total, b_perr} !== '0) begin
            fails++; $display("FAIL reset_b got ready=%b drive=%h tot=%h", b_ready, b_drive, b_total);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        req_a(64'h0000_0000_0000_00A5, '0, -1, 1'b0);
        checks++;
        if (a_cnt !== SCW'(4)) begin fails++; $display("FAIL basic_count got=%0d exp=4", a_cnt); end
        for (int i = 0; i < 3; i++) req_a(rnd64(), '0, -1, 1'b0);
    endtask

    task automatic test_pending();
        req_a(rnd64(), '0, -1, 1'b1);
        req_a(rnd64(), '0, -1, 1'b1);
        req_a(rnd64(), '0, -1, 1'b0);
    endtask

    // dac_valid withdrawn after observation drop_k: error pulse one cycle later, never a drive.
    task automatic test_protocol_err();
        int drop_k;
        logic exp_rdy;
        for (int t = 0; t < 4; t++) begin
            drop_k = (t == 3) ? ACK_K : int'($urandom_range(0, ACK_K - 1));
            a_valid = 1'b1; a_spike = rnd64();
            for (int k = 0; k <= drop_k + 3; k++) begin
                @(posedge clk); @(negedge clk);
                exp_rdy = (k == ACK_K) && (drop_k >= ACK_K);
                checks++;
                if (a_ready !== exp_rdy) begin fails++; $display("FAIL perr_ready k=%0d got=%b exp=%b", k, a_ready, exp_rdy); end
                checks++;
                if (a_perr !== (k == drop_k + 1)) begin fails++; $display("FAIL perr_pulse k=%0d drop=%0d got=%b", k, drop_k, a_perr); end
                checks++;
                if (a_drive !== '0 || a_active !== 1'b0) begin
                    fails++; $display("FAIL perr_drive k=%0d got=%h act=%b exp=0", k, a_drive, a_active);
                end
                if (k == drop_k) a_valid = 1'b0;
            end
            checks++;
            if (a_total !== exp_total) begin fails++; $display("FAIL perr_total got=%h exp=%h", a_total, exp_total); end
        end
    endtask

    task automatic test_spike_sampling();
        req_a(rnd64(), rnd64(), 1, 1'b0);
        req_a(rnd64(), 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    endtask

    task automatic test_reset_mid_drive();
        a_valid = 1'b1; a_spike = '1;
        for (int k = 0; k <= ACK_K + 2; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == ACK_K + 1) a_valid = 1'b0;
        end
        checks++;
        if (a_drive !== '1) begin fails++; $display("FAIL mid_drive_pre got=%h exp=all-ones", a_drive); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_drive !== '0 || a_active !== 1'b0 || a_total !== '0) begin
            fails++; $display("FAIL async_reset got drive=%h act=%b tot=%h exp=0", a_drive, a_active, a_total);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_total = '0;
        req_a(rnd64(), '0, -1, 1'b0);
        checks++;
        if (a_total !== 16'd1) begin fails++; $display("FAIL after_reset_total got=%h exp=0001", a_total); end
    endtask

    task automatic test_wrap();
        force dut_a.r_pulse_total = 16'hFFFF;
        #1 release dut_a.r_pulse_total;
        exp_total = 16'hFFFF;
        checks++;
        if (a_total !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload got=%h exp=ffff", a_total); end
        req_a('0, '0, -1, 1'b0);
        checks++;
        if (a_total !== 16'h0000 || a_cnt !== '0) begin
            fails++; $display("FAIL wrap_zero got tot=%h cnt=%0d exp tot=0000 cnt=0", a_total, a_cnt);
        end
        req_a(rnd64(), '0, -1, 1'b0);
    endtask

    // Fast instance: valid dropped after each handshake and re-raised as soon as the
    // responder can accept again, giving one request every PER_B cycles.
    task automatic test_back_to_back();
        localparam int NREQ = 6;
        logic [N-1:0] bms [NREQ];
        logic [N-1:0] exp_drv;
        int j, ph;
        for (int i = 0; i < NREQ; i++) bms[i] = (i == 2) ? '0 : rnd64();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        b_valid = 1'b1; b_spike = bms[0];
        for (int k = 0; k < NREQ * PER_B; k++) begin
            @(posedge clk); @(negedge clk);
            j = k / PER_B; ph = k % PER_B;
            exp_drv = (ph > ACK_B && ph <= ACK_B + PCB) ? bms[j] : '0;
            checks++;
            if (b_ready !== (ph == ACK_B)) begin fails++; $display("FAIL b2b_ready k=%0d got=%b", k, b_ready); end
            checks++;
            if (b_drive !== exp_drv) begin fails++; $display("FAIL b2b_drive k=%0d got=%h exp=%h", k, b_drive, exp_drv); end
            checks++;
            if (b_perr !== 1'b0) begin fails++; $display("FAIL b2b_perr k=%0d got=%b exp=0", k, b_perr); end
            if (ph == ACK_B + 1) begin
                checks++;
                if (int'(b_cnt) !== $countones(bms[j])) begin
                    fails++; $display("FAIL b2b_count k=%0d got=%0d exp=%0d", k, b_cnt, $countones(bms[j]));
                end
                b_valid = 1'b0; b_spike = rnd64();
            end
            if (ph == PER_B - 1 && j < NREQ - 1) begin b_valid = 1'b1; b_spike = bms[j + 1]; end
        end
        checks++;
        if (b_total !== 16'(NREQ)) begin fails++; $display("FAIL b2b_total got=%0d exp=%0d", b_total, NREQ); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pending();
        test_protocol_err();
        test_spike_sampling();
        test_reset_mid_drive();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
